// File: rtl/pipe_ctrl_pkg.sv
// Shared types and helpers for the pipeline sequencing controller.
package pipe_ctrl_pkg;

  typedef enum logic [0:0] {
    ST_RUN     = 1'b0,
    ST_MD_WAIT = 1'b1
  } md_state_e;

  localparam int unsigned MD_CYCLES_DEF = 32'd32;

  // Ceiling log2 with a floor of one bit so a one-cycle latency still has a counter.
  function automatic int unsigned clog2_min1(input int unsigned v);
    int unsigned r;
    r = 32'd0;
    for (int i = 0; i < 32; i++) begin
      if ((32'd1 << i) < v) r = i + 1;
      else r = r;
    end
    if (r == 32'd0) return 32'd1;
    else return r;
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: clear, saturating increment, or hold.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) cnt_d = {W{1'b0}};
    else if (inc_i && (cnt_q != {W{1'b1}})) cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
    else cnt_d = cnt_q;
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= {W{1'b0}};
    else        cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller: load-use and HI/LO hazards, branch squash,
// mult/div busy window and a saturating front-end stall counter.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned bREG      = 5,
  parameter int unsigned MD_CYCLES = MD_CYCLES_DEF,
  parameter int unsigned bCNT      = 16
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            IDEX_MemRead,
  input  logic [bREG-1:0] IDEX_Rt,
  input  logic [bREG-1:0] IFID_Rs,
  input  logic [bREG-1:0] IFID_Rt,
  input  logic            IFID_UsesRt,
  input  logic            IFID_IsMD,
  input  logic            IFID_ReadsHiLo,
  input  logic            EX_MDStart,
  input  logic            EX_BranchTaken,
  input  logic            clrStats,
  output logic            enPC,
  output logic            enIFID,
  output logic            flushIFID,
  output logic            flushIDEX,
  output logic            mdBusy,
  output logic            mdDone,
  output logic [bCNT-1:0] stallCycles
);

  localparam int unsigned    CW       = clog2_min1(MD_CYCLES);
  localparam logic [CW-1:0]  CNT_LOAD = CW'(MD_CYCLES - 32'd1);

  md_state_e     state_q;
  logic [CW-1:0] md_cnt_q;
  logic          md_done_q;

  logic load_use_s;
  logic md_haz_s;
  logic stall_s;

  // Hazard equations; outputs are forced to their idle values while reset is held.
  always_comb begin
    load_use_s = IDEX_MemRead & (IDEX_Rt != {bREG{1'b0}}) &
                 ((IDEX_Rt == IFID_Rs) | (IFID_UsesRt & (IDEX_Rt == IFID_Rt)));
    md_haz_s   = (state_q == ST_MD_WAIT) & (IFID_ReadsHiLo | IFID_IsMD);
    stall_s    = (load_use_s | md_haz_s) & ~EX_BranchTaken & reset;
    enPC       = ~stall_s;
    enIFID     = ~stall_s;
    flushIDEX  = (stall_s | EX_BranchTaken) & reset;
    flushIFID  = EX_BranchTaken & reset;
  end

  // Mult/div busy FSM; a start during MD_WAIT cannot occur and is ignored.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_RUN;
      md_cnt_q  <= {CW{1'b0}};
      md_done_q <= 1'b0;
    end else begin
      case (state_q)
        ST_RUN: begin
          md_done_q <= 1'b0;
          if (EX_MDStart) begin
            state_q  <= ST_MD_WAIT;
            md_cnt_q <= CNT_LOAD;
          end else begin
            state_q  <= ST_RUN;
            md_cnt_q <= md_cnt_q;
          end
        end
        ST_MD_WAIT: begin
          if (md_cnt_q == {CW{1'b0}}) begin
            state_q   <= ST_RUN;
            md_done_q <= 1'b1;
          end else begin
            state_q   <= ST_MD_WAIT;
            md_cnt_q  <= md_cnt_q - {{(CW-1){1'b0}}, 1'b1};
            md_done_q <= 1'b0;
          end
        end
        default: begin
          state_q   <= ST_RUN;
          md_cnt_q  <= {CW{1'b0}};
          md_done_q <= 1'b0;
        end
      endcase
    end
  end

  assign mdBusy = (state_q == ST_MD_WAIT);
  assign mdDone = md_done_q;

  sat_counter #(.W(bCNT)) u_stall_cnt (
    .clk   (clock),
    .rst_n (reset),
    .clr_i (clrStats),
    .inc_i (~enPC),
    .cnt_o (stallCycles)
  );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl (MD_CYCLES=4, bCNT=4).
module tb_pipe_hazard_ctrl;

  logic       clock, reset;
  logic       IDEX_MemRead;
  logic [4:0] IDEX_Rt, IFID_Rs, IFID_Rt;
  logic       IFID_UsesRt, IFID_IsMD, IFID_ReadsHiLo;
  logic       EX_MDStart, EX_BranchTaken, clrStats;
  logic       enPC, enIFID, flushIFID, flushIDEX, mdBusy, mdDone;
  logic [3:0] stallCycles;
  logic [3:0] ctl;

  int tests = 0;
  int fails = 0;
  int exp_cnt = 0;

  pipe_hazard_ctrl #(.bREG(5), .MD_CYCLES(4), .bCNT(4)) dut (
    .clock(clock), .reset(reset),
    .IDEX_MemRead(IDEX_MemRead), .IDEX_Rt(IDEX_Rt),
    .IFID_Rs(IFID_Rs), .IFID_Rt(IFID_Rt), .IFID_UsesRt(IFID_UsesRt),
    .IFID_IsMD(IFID_IsMD), .IFID_ReadsHiLo(IFID_ReadsHiLo),
    .EX_MDStart(EX_MDStart), .EX_BranchTaken(EX_BranchTaken), .clrStats(clrStats),
    .enPC(enPC), .enIFID(enIFID), .flushIFID(flushIFID), .flushIDEX(flushIDEX),
    .mdBusy(mdBusy), .mdDone(mdDone), .stallCycles(stallCycles)
  );

  assign ctl = {enPC, enIFID, flushIFID, flushIDEX};

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("FAIL timeout reached");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    IDEX_MemRead = 1'b0; IDEX_Rt = 5'd0; IFID_Rs = 5'd0; IFID_Rt = 5'd0;
    IFID_UsesRt = 1'b0; IFID_IsMD = 1'b0; IFID_ReadsHiLo = 1'b0;
    EX_MDStart = 1'b0; EX_BranchTaken = 1'b0; clrStats = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    idle();
    tick(); tick();
    tests++; if (ctl !== 4'b1100) begin fails++; $display("FAIL rst_ctl got %b exp %b", ctl, 4'b1100); end
    tests++; if (mdBusy !== 1'b0 || mdDone !== 1'b0) begin fails++; $display("FAIL rst_md got %b%b exp 00", mdBusy, mdDone); end
    tests++; if (stallCycles !== 4'd0) begin fails++; $display("FAIL rst_cnt got %0d exp 0", stallCycles); end
    IDEX_MemRead = 1'b1; IDEX_Rt = 5'd8; IFID_Rs = 5'd8;
    #1;
    tests++; if (ctl !== 4'b1100) begin fails++; $display("FAIL rst_hold_ctl got %b exp %b", ctl, 4'b1100); end
    idle();
    tick();
    reset = 1'b1;
    #1;
  endtask

  task automatic test_load_use();
    IDEX_MemRead = 1'b1; IDEX_Rt = 5'd8; IFID_Rs = 5'd8;
    #1;
    tests++; if (ctl !== 4'b0001) begin fails++; $display("FAIL lu_ctl got %b exp %b", ctl, 4'b0001); end
    tick(); exp_cnt++;
    IDEX_MemRead = 1'b0;
    #1;
    tests++; if (ctl !== 4'b1100) begin fails++; $display("FAIL lu_release got %b exp %b", ctl, 4'b1100); end
    tests++; if (stallCycles !== exp_cnt[3:0]) begin fails++; $display("FAIL lu_cnt got %0d exp %0d", stallCycles, exp_cnt); end
    IDEX_MemRead = 1'b1; IDEX_Rt = 5'd0; IFID_Rs = 5'd0;
    #1;
    tests++; if (ctl !== 4'b1100) begin fails++; $display("FAIL lu_r0 got %b exp %b", ctl, 4'b1100); end
    IDEX_Rt = 5'd5; IFID_Rs = 5'd3; IFID_Rt = 5'd5; IFID_UsesRt = 1'b1;
    #1;
    tests++; if (ctl !== 4'b0001) begin fails++; $display("FAIL lu_rt got %b exp %b", ctl, 4'b0001); end
    IFID_UsesRt = 1'b0;
    #1;
    tests++; if (ctl !== 4'b1100) begin fails++; $display("FAIL lu_rt_unused got %b exp %b", ctl, 4'b1100); end
    idle();
  endtask

  task automatic test_branch_override();
    IDEX_MemRead = 1'b1; IDEX_Rt = 5'd8; IFID_Rs = 5'd8; EX_BranchTaken = 1'b1;
    #1;
    tests++; if (ctl !== 4'b1111) begin fails++; $display("FAIL br_ctl got %b exp %b", ctl, 4'b1111); end
    tick();
    idle();
    #1;
    tests++; if (stallCycles !== exp_cnt[3:0]) begin fails++; $display("FAIL br_cnt got %0d exp %0d", stallCycles, exp_cnt); end
  endtask

  task automatic test_md_window();
    EX_MDStart = 1'b1;
    #1;
    tests++; if (ctl !== 4'b1100 || mdBusy !== 1'b0) begin fails++; $display("FAIL md_start got %b/%b exp 1100/0", ctl, mdBusy); end
    tick();
    EX_MDStart = 1'b0; IFID_ReadsHiLo = 1'b1;
    #1;
    for (int k = 1; k <= 4; k++) begin
      tests++;
      if (mdBusy !== 1'b1 || mdDone !== 1'b0 || ctl !== 4'b0001) begin
        fails++; $display("FAIL md_busy%0d got busy=%b done=%b ctl=%b exp 1/0/0001", k, mdBusy, mdDone, ctl);
      end
      tick(); exp_cnt++;
    end
    tests++; if (mdBusy !== 1'b0 || mdDone !== 1'b1 || ctl !== 4'b1100) begin
      fails++; $display("FAIL md_done got busy=%b done=%b ctl=%b exp 0/1/1100", mdBusy, mdDone, ctl); end
    tests++; if (stallCycles !== exp_cnt[3:0]) begin fails++; $display("FAIL md_cnt got %0d exp %0d", stallCycles, exp_cnt); end
    IFID_ReadsHiLo = 1'b0;
    tick();
    tests++; if (mdDone !== 1'b0) begin fails++; $display("FAIL md_done_pulse got %b exp 0", mdDone); end
    EX_MDStart = 1'b1;
    tick();
    EX_MDStart = 1'b0;
    #1;
    tests++; if (mdBusy !== 1'b1 || ctl !== 4'b1100) begin fails++; $display("FAIL md_add got busy=%b ctl=%b exp 1/1100", mdBusy, ctl); end
    repeat (4) tick();
    tests++; if (mdDone !== 1'b1 || mdBusy !== 1'b0) begin fails++; $display("FAIL md_add_done got done=%b busy=%b exp 1/0", mdDone, mdBusy); end
    tick();
  endtask

  task automatic test_back_to_back();
    EX_MDStart = 1'b1; EX_BranchTaken = 1'b1;
    #1;
    tests++; if (ctl !== 4'b1111) begin fails++; $display("FAIL b2b_br got %b exp %b", ctl, 4'b1111); end
    tick();
    EX_MDStart = 1'b0; EX_BranchTaken = 1'b0; IFID_IsMD = 1'b1;
    #1;
    for (int k = 1; k <= 4; k++) begin
      tests++;
      if (mdBusy !== 1'b1 || ctl !== 4'b0001) begin
        fails++; $display("FAIL b2b_hold%0d got busy=%b ctl=%b exp 1/0001", k, mdBusy, ctl);
      end
      tick(); exp_cnt++;
    end
    tests++; if (mdDone !== 1'b1 || ctl !== 4'b1100) begin fails++; $display("FAIL b2b_rel got done=%b ctl=%b exp 1/1100", mdDone, ctl); end
    tick();
    IFID_IsMD = 1'b0; EX_MDStart = 1'b1;
    #1;
    tests++; if (mdBusy !== 1'b0) begin fails++; $display("FAIL b2b_gap got %b exp 0", mdBusy); end
    tick();
    EX_MDStart = 1'b0;
    #1;
    tests++; if (mdBusy !== 1'b1) begin fails++; $display("FAIL b2b_second got %b exp 1", mdBusy); end
    repeat (4) tick();
    tests++; if (mdDone !== 1'b1 || mdBusy !== 1'b0) begin fails++; $display("FAIL b2b_second_done got done=%b busy=%b exp 1/0", mdDone, mdBusy); end
    tests++; if (stallCycles !== exp_cnt[3:0]) begin fails++; $display("FAIL b2b_cnt got %0d exp %0d", stallCycles, exp_cnt); end
    tick();
  endtask

  task automatic test_saturation();
    clrStats = 1'b1;
    tick();
    clrStats = 1'b0;
    #1;
    tests++; if (stallCycles !== 4'd0) begin fails++; $display("FAIL sat_clr got %0d exp 0", stallCycles); end
    IDEX_MemRead = 1'b1; IDEX_Rt = 5'd8; IFID_Rs = 5'd8;
    repeat (20) tick();
    tests++; if (stallCycles !== 4'd15) begin fails++; $display("FAIL sat_20 got %0d exp 15", stallCycles); end
    tick();
    tests++; if (stallCycles !== 4'd15) begin fails++; $display("FAIL sat_hold got %0d exp 15", stallCycles); end
    clrStats = 1'b1;
    tick();
    clrStats = 1'b0;
    #1;
    tests++; if (stallCycles !== 4'd0) begin fails++; $display("FAIL sat_clr_prio got %0d exp 0", stallCycles); end
    tick();
    tests++; if (stallCycles !== 4'd1) begin fails++; $display("FAIL sat_restart got %0d exp 1", stallCycles); end
    idle();
    #1;
  endtask

  task automatic test_async_reset_mid_md();
    int seen_done;
    seen_done = 0;
    EX_MDStart = 1'b1;
    tick();
    EX_MDStart = 1'b0;
    tick();
    #2;
    reset = 1'b0;
    #1;
    tests++; if (mdBusy !== 1'b0 || ctl !== 4'b1100) begin fails++; $display("FAIL arst_busy got busy=%b ctl=%b exp 0/1100", mdBusy, ctl); end
    tests++; if (stallCycles !== 4'd0) begin fails++; $display("FAIL arst_cnt got %0d exp 0", stallCycles); end
    tick(); tick();
    reset = 1'b1;
    for (int k = 0; k < 6; k++) begin
      #1;
      if (mdDone !== 1'b0 || mdBusy !== 1'b0) seen_done++;
      tick();
    end
    tests++; if (seen_done !== 0) begin fails++; $display("FAIL arst_no_done got %0d bad cycles exp 0", seen_done); end
    IFID_ReadsHiLo = 1'b1;
    #1;
    tests++; if (ctl !== 4'b1100) begin fails++; $display("FAIL arst_run got %b exp %b", ctl, 4'b1100); end
    idle();
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_branch_override();
    test_md_window();
    test_back_to_back();
    test_saturation();
    test_async_reset_mid_md();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Pipeline sequencing controller for the five-stage MIPS core. Drives the write-enables and flush controls of the PC and the IF/ID and ID/EX pipeline registers. It resolves load-use hazards, taken-branch squashes and the multi-cycle multiply/divide busy window. It also keeps a saturating count of front-end stall cycles for performance debug.

## Interface
- `bREG`, 5: register-specifier width (rs/rt fields).
- `MD_CYCLES`, 32: multiply/divide latency in cycles, ≥1.
- `bCNT`, 16: width of the stall-cycle counter.

- `clock`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-low; clears all state immediately.
- `IDEX_MemRead`  in  1  instruction in EX is a load.
- `IDEX_Rt`  in  bREG  load destination in EX.
- `IFID_Rs`  in  bREG  rs of instruction in ID.
- `IFID_Rt`  in  bREG  rt of instruction in ID.
- `IFID_UsesRt`  in  1  ID instruction reads rt.
- `IFID_IsMD`  in  1  ID instruction is mult/div.
- `IFID_ReadsHiLo`  in  1  ID instruction is mfhi/mflo.
- `EX_MDStart`  in  1  EX instruction is mult/div (one-cycle pulse).
- `EX_BranchTaken`  in  1  branch/jump resolved taken in EX.
- `clrStats`  in  1  synchronous clear of `stallCycles`.
- `enPC`  out  1  PC write-enable.
- `enIFID`  out  1  IF/ID write-enable.
- `flushIFID`  out  1  IF/ID loads a NOP.
- `flushIDEX`  out  1  ID/EX loads a bubble.
- `mdBusy`  out  1  HI/LO not yet valid.
- `mdDone`  out  1  one-cycle pulse when HI/LO becomes valid.
- `stallCycles`  out  bCNT  saturating count of cycles with `enPC`=0.

## Operation
- FSM states: RUN, MD_WAIT. A down-counter `mdCnt` has width clog2(MD_CYCLES).
- `loadUse` = `IDEX_MemRead` & (`IDEX_Rt`≠0) & (`IDEX_Rt`==`IFID_Rs` | (`IFID_UsesRt` & `IDEX_Rt`==`IFID_Rt`)).
- `mdHaz` = (state==MD_WAIT) & (`IFID_ReadsHiLo` | `IFID_IsMD`).
- `stall` = (`loadUse` | `mdHaz`) & ~`EX_BranchTaken`.
- Control outputs:
  - `enPC` = `enIFID` = ~`stall`.
  - `flushIDEX` = `stall` | `EX_BranchTaken`.
  - `flushIFID` = `EX_BranchTaken`.
- Priority: a taken branch overrides any stall. The ID instruction is on the wrong path, so the PC advances to the target and both IF/ID and ID/EX are squashed.
- RUN → MD_WAIT on `EX_MDStart`, with `mdCnt` ← MD_CYCLES−1.
- MD_WAIT:
  - `mdCnt` decrements each edge.
  - When `mdCnt`==0, next state is RUN and `mdDone` ← 1 for one cycle.
  - `EX_MDStart` is ignored in MD_WAIT. It cannot legally occur because `mdHaz` holds any mult/div in ID.
- `EX_MDStart` together with `EX_BranchTaken`: both are honoured, the busy window starts and the flush occurs.
- `mdBusy` = (state==MD_WAIT).
- `stallCycles`:
  - Increments on each edge where `enPC`=0.
  - Saturates at all-ones; never wraps.
  - `clrStats` clears it and takes priority over the increment.
- Reset values, held while `reset`=0:
  - State RUN, `mdCnt`=0, `mdDone`=0, `stallCycles`=0.
  - `enPC`=`enIFID`=1, `flushIFID`=`flushIDEX`=0, `mdBusy`=0.
- Reset mid-MD_WAIT abandons the operation; no `mdDone` pulse is issued.

## Timing
- Stall, flush and enable outputs are combinational from the current inputs and state. They have zero-cycle latency, and the pipeline registers act on them at the next edge.
- A load-use stall lasts exactly one cycle. When the load leaves EX, `loadUse` drops.
- `EX_MDStart` sampled high in cycle T:
  - `mdBusy` is high for cycles T+1 … T+MD_CYCLES.
  - `mdDone` is high in cycle T+MD_CYCLES+1.
  - A waiting mfhi/mflo in ID advances in cycle T+MD_CYCLES+1.
- MD_CYCLES=1 gives a single busy cycle.
- `stallCycles` lags `enPC` by one edge.

## Structure
- Shared package (`pipe_ctrl_pkg`) holds:
  - the FSM state encoding (RUN=0, MD_WAIT=1);
  - the MD_CYCLES default;
  - the clog2 helper used for the `mdCnt` width.
- One sub-module, `sat_counter`, parameterised by width, with increment and clear inputs, saturating at all-ones. It implements `stallCycles`.
- The FSM, `mdCnt` and hazard equations stay in the top level.

## Test plan
- **Load-use stall:** `IDEX_MemRead`=1, `IDEX_Rt`=8, `IFID_Rs`=8 → `enPC`=`enIFID`=0 and `flushIDEX`=1 for one cycle; `stallCycles` 0→1. With `IDEX_Rt`=0 → no stall.
- **Branch overrides stall:** load-use condition plus `EX_BranchTaken`=1 → `enPC`=1, `flushIFID`=`flushIDEX`=1, and `stallCycles` unchanged.
- **MD window:** MD_CYCLES=4, `EX_MDStart` pulse in cycle 10 → `mdBusy` high in cycles 11–14 and `mdDone` high in cycle 15. mfhi held in ID during 11–14 with `flushIDEX`=1, and released in cycle 15. An unrelated add in ID is not stalled.
- **Counter saturation:** bCNT=4, hold a stall for 20 cycles → `stallCycles`=15 and held. `clrStats` together with a stall → 0.
- **Async reset mid-MD:** `reset` low in cycle 12 of a window → `mdBusy`=0 immediately, no `mdDone`, state RUN after release.
- **Back-to-back MD:** a second mult in ID during MD_WAIT → held until RUN, then `EX_MDStart` at cycle T+MD_CYCLES+2 starts a new window.
